// File: rtl/dsp_hdlc_rx_ctrl.sv
// rtl/dsp_hdlc_rx_ctrl.sv - HDLC receive buffer controller packing bytes into a 16-bit DSP RAM
//
// Packs deframed HDLC payload bytes into 16-bit words, writes them to the DSP
// dual-port RAM, latches the frame length and status, and raises a stretched
// interrupt. The buffer is then held until the DSP acknowledges.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   rx_vld     in   1   rx_byte valid strobe
//   rx_byte    in   8   payload byte (FCS stripped)
//   rx_eof     in   1   good end-of-frame pulse
//   rx_abort   in   1   abort / FCS error pulse, frame discarded
//   dsp_ack    in   1   DSP has consumed the buffer
//   ram_wen    out  1   RAM write enable, one cycle per word
//   ram_addr   out  8   RAM word address
//   ram_wdata  out  16  RAM word, even byte in [7:0], odd byte in [15:8]
//   rx_len     out  10  byte count of last delivered frame
//   rx_status  out  2   [0] too_long, [1] frame dropped while buffer full
//   drop_cnt   out  8   frames dropped while buffer full, saturating
//   rx_int     out  1   frame-ready interrupt, INT_WIDTH cycles
//   buf_full   out  1   buffer held for the DSP
module dsp_hdlc_rx_ctrl #(
    parameter logic [9:0] MAX_BYTES = 10'd512,
    parameter logic [9:0] INT_WIDTH = 10'd500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_byte,
    input  logic        rx_eof,
    input  logic        rx_abort,
    input  logic        dsp_ack,
    output logic        ram_wen,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic [9:0]  rx_len,
    output logic [1:0]  rx_status,
    output logic [7:0]  drop_cnt,
    output logic        rx_int,
    output logic        buf_full
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RECV     = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  count_q, count_d;
    logic [7:0]  hold_q, hold_d;
    logic        too_long_q, too_long_d;
    logic [9:0]  int_cnt_q, int_cnt_d;
    logic        rx_int_q, rx_int_d;
    logic        ram_wen_q, ram_wen_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic [9:0]  rx_len_q, rx_len_d;
    logic [1:0]  rx_status_q, rx_status_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        accepting;
    logic        byte_take;
    logic [9:0]  frame_len;
    logic        deliver;

    // Bytes are only taken while a frame can be built; beyond MAX_BYTES they
    // are dropped and the count saturates so rx_len reports MAX_BYTES.
    assign accepting = (state_q == S_IDLE) || ((state_q == S_RECV) && !rx_abort);
    assign byte_take = rx_vld && accepting && (count_q < MAX_BYTES);
    // Length including a byte arriving in the same cycle as rx_eof.
    assign frame_len = count_q + {9'd0, byte_take};
    assign deliver   = (state_q == S_RECV) && rx_eof && !rx_abort && (frame_len != 10'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_vld) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_abort) begin
                    state_d = S_IDLE;
                end else if (deliver) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (dsp_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        count_d     = count_q;
        hold_d      = hold_q;
        too_long_d  = too_long_q;
        int_cnt_d   = int_cnt_q;
        rx_int_d    = rx_int_q;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rx_len_d    = rx_len_q;
        rx_status_d = rx_status_q;
        drop_cnt_d  = drop_cnt_q;

        // Interrupt stretch: counter holds k during the k-th high cycle.
        if (rx_int_q) begin
            if (int_cnt_q >= INT_WIDTH) begin
                rx_int_d  = 1'b0;
                int_cnt_d = 10'd0;
            end else begin
                int_cnt_d = int_cnt_q + 10'd1;
            end
        end

        case (state_q)
            S_IDLE, S_RECV: begin
                if ((state_q == S_RECV) && rx_abort) begin
                    count_d    = 10'd0;
                    too_long_d = 1'b0;
                end else begin
                    if (rx_vld) begin
                        if (byte_take) begin
                            count_d = count_q + 10'd1;
                            if (!count_q[0]) begin
                                hold_d = rx_byte;
                            end else begin
                                ram_wen_d   = 1'b1;
                                ram_addr_d  = count_q[8:1];
                                ram_wdata_d = {rx_byte, hold_q};
                            end
                        end else begin
                            too_long_d = 1'b1;
                        end
                    end
                    if (deliver) begin
                        // An odd length leaves a half word in hold; flush it.
                        if (frame_len[0]) begin
                            ram_wen_d   = 1'b1;
                            ram_addr_d  = frame_len[8:1];
                            ram_wdata_d = {8'h00, hold_d};
                        end
                        rx_len_d    = frame_len;
                        rx_status_d = {1'b0, too_long_d};
                        rx_int_d    = 1'b1;
                        int_cnt_d   = 10'd1;
                        count_d     = 10'd0;
                        too_long_d  = 1'b0;
                        hold_d      = 8'h00;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (dsp_ack) begin
                    rx_int_d    = 1'b0;
                    int_cnt_d   = 10'd0;
                    rx_status_d = 2'b00;
                    drop_cnt_d  = 8'd0;
                end else if (rx_eof) begin
                    rx_status_d[1] = 1'b1;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                count_d = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 10'd0;
            hold_q      <= 8'h00;
            too_long_q  <= 1'b0;
            int_cnt_q   <= 10'd0;
            rx_int_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= 8'h00;
            ram_wdata_q <= 16'h0000;
            rx_len_q    <= 10'd0;
            rx_status_q <= 2'b00;
            drop_cnt_q  <= 8'd0;
        end else begin
            count_q     <= count_d;
            hold_q      <= hold_d;
            too_long_q  <= too_long_d;
            int_cnt_q   <= int_cnt_d;
            rx_int_q    <= rx_int_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rx_len_q    <= rx_len_d;
            rx_status_q <= rx_status_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        buf_full = (state_q == S_WAIT_ACK);
    end

    assign ram_wen   = ram_wen_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign rx_len    = rx_len_q;
    assign rx_status = rx_status_q;
    assign drop_cnt  = drop_cnt_q;
    assign rx_int    = rx_int_q;

endmodule

// File: tb/tb_dsp_hdlc_rx_ctrl.sv
// tb/tb_dsp_hdlc_rx_ctrl.sv - scoreboard bench for dsp_hdlc_rx_ctrl
module tb_dsp_hdlc_rx_ctrl;

    localparam int MAXB = 512;
    localparam int INTW = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_eof = 1'b0;
    logic        rx_abort = 1'b0;
    logic        dsp_ack = 1'b0;
    logic        ram_wen;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [9:0]  rx_len;
    logic [1:0]  rx_status;
    logic [7:0]  drop_cnt;
    logic        rx_int;
    logic        buf_full;

    dsp_hdlc_rx_ctrl #(
        .MAX_BYTES(10'd512),
        .INT_WIDTH(10'd500)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_vld   (rx_vld),
        .rx_byte  (rx_byte),
        .rx_eof   (rx_eof),
        .rx_abort (rx_abort),
        .dsp_ack  (dsp_ack),
        .ram_wen  (ram_wen),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .rx_len   (rx_len),
        .rx_status(rx_status),
        .drop_cnt (drop_cnt),
        .rx_int   (rx_int),
        .buf_full (buf_full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_eof = 0;

    logic [23:0] exp_wr[$];   // {addr, data}
    logic [10:0] exp_dl[$];   // {too_long, len}
    int          exp_w[$];    // rx_int high cycles
    logic [7:0]  fb[$];       // frame bytes for the next run_frame

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every DUT write, delivery and interrupt width
    logic        prev_int = 1'b0;
    int          int_w = 0;
    logic [23:0] e_wr;
    logic [10:0] e_dl;
    int          e_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_int = 1'b0;
            int_w    = 0;
        end else begin
            if (ram_wen) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if ({ram_addr, ram_wdata} !== e_wr) begin
                        n_err++;
                        $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h",
                                 ram_addr, ram_wdata, e_wr[23:16], e_wr[15:0]);
                    end
                end
            end
            if (rx_int && !prev_int) begin
                n_vec++;
                if (exp_dl.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_delivery: rx_len %0d", rx_len);
                end else begin
                    e_dl = exp_dl.pop_front();
                    if (rx_len !== e_dl[9:0] || rx_status !== {1'b0, e_dl[10]} || buf_full !== 1'b1) begin
                        n_err++;
                        $display("FAIL delivery: got len %0d status %0b buf_full %0b expected len %0d status %0b buf_full 1",
                                 rx_len, rx_status, buf_full, e_dl[9:0], {1'b0, e_dl[10]});
                    end
                end
            end
            if (rx_int) begin
                int_w++;
            end else if (prev_int) begin
                n_vec++;
                if (exp_w.size() == 0) begin
                    n_err++;
                    $display("FAIL int_width: got %0d cycles, none expected", int_w);
                end else begin
                    e_w = exp_w.pop_front();
                    if (int_w != e_w) begin
                        n_err++;
                        $display("FAIL int_width: got %0d cycles expected %0d", int_w, e_w);
                    end
                end
                int_w = 0;
            end
            prev_int = rx_int;
        end
    end

    // mode: 0 eof after last byte, 1 eof with last byte, 2 abort, 3 dropped while full
    task automatic run_frame(input int mode);
        int          len;
        int          k;
        logic [15:0] wd;
        len = fb.size();
        k   = (len > MAXB) ? MAXB : len;
        if (mode == 0 || mode == 1) begin
            for (int w = 0; w < (k + 1) / 2; w++) begin
                wd = {((2 * w + 1 < k) ? fb[2 * w + 1] : 8'h00), fb[2 * w]};
                exp_wr.push_back({w[7:0], wd});
            end
            exp_dl.push_back({(len > MAXB), k[9:0]});
        end else if (mode == 2) begin
            for (int w = 0; w < len / 2; w++) begin
                wd = {fb[2 * w + 1], fb[2 * w]};
                exp_wr.push_back({w[7:0], wd});
            end
        end
        for (int i = 0; i < len; i++) begin
            rx_vld  = 1'b1;
            rx_byte = fb[i];
            if (mode == 1 && i == len - 1) rx_eof = 1'b1;
            cycle();
            if (mode == 1 && i == len - 1) t_eof = cyc;
            rx_vld = 1'b0;
            rx_eof = 1'b0;
            cycle();
        end
        if (mode == 0 || mode == 3) begin
            rx_eof = 1'b1;
            cycle();
            if (mode == 0) t_eof = cyc;
            rx_eof = 1'b0;
        end
        if (mode == 2) begin
            rx_abort = 1'b1;
            cycle();
            rx_abort = 1'b0;
        end
    endtask

    task automatic rand_fill(input int len);
        fb.delete();
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    endtask

    // Ack d cycles after the delivery edge; rx_int stays high until the ack
    // edge or INT_WIDTH cycles, whichever is first.
    task automatic do_ack(input int d);
        int c;
        int w;
        c = (cyc > t_eof + d) ? cyc : t_eof + d;
        w = c - t_eof + 1;
        if (w > INTW) w = INTW;
        exp_w.push_back(w);
        while (cyc < t_eof + d) cycle();
        chk("buf_full_before_ack", {31'd0, buf_full}, 32'd1);
        dsp_ack = 1'b1;
        cycle();
        dsp_ack = 1'b0;
        chk("rx_int_after_ack", {31'd0, rx_int}, 32'd0);
        chk("buf_full_after_ack", {31'd0, buf_full}, 32'd0);
        chk("rx_status_after_ack", {30'd0, rx_status}, 32'd0);
        chk("drop_cnt_after_ack", {24'd0, drop_cnt}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("reset_ram_wen", {31'd0, ram_wen}, 32'd0);
        chk("reset_ram_addr", {24'd0, ram_addr}, 32'd0);
        chk("reset_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("reset_rx_len", {22'd0, rx_len}, 32'd0);
        chk("reset_rx_status", {30'd0, rx_status}, 32'd0);
        chk("reset_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("reset_rx_int", {31'd0, rx_int}, 32'd0);
        chk("reset_buf_full", {31'd0, buf_full}, 32'd0);

        // 5-byte frame, full-length interrupt
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_frame(0);
        do_ack(520);

        // 4 bytes with eof on the last byte
        fb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_frame(1);
        do_ack(10);

        // 3 bytes then abort
        fb = '{8'h01, 8'h02, 8'h03};
        run_frame(2);
        cycle();
        chk("abort_rx_len_kept", {22'd0, rx_len}, 32'd4);
        chk("abort_no_int", {31'd0, rx_int}, 32'd0);
        chk("abort_not_full", {31'd0, buf_full}, 32'd0);

        // Delivered frame, then two dropped frames, ack at rx_int cycle 100
        rand_fill($urandom_range(1, 20));
        run_frame(0);
        len = t_eof;
        rand_fill(3);
        run_frame(3);
        rand_fill(2);
        run_frame(3);
        t_eof = len;
        chk("drop_cnt_two", {24'd0, drop_cnt}, 32'd2);
        chk("drop_status_bit1", {31'd0, rx_status[1]}, 32'd1);
        do_ack(99);

        // Over-long frame
        rand_fill(520);
        run_frame(0);
        do_ack($urandom_range(1, 50));

        // Random frames
        for (int f = 0; f < 6; f++) begin
            rand_fill($urandom_range(1, 40));
            run_frame($urandom_range(0, 1));
            do_ack($urandom_range(1, 600));
        end

        // Reset after the first byte of a frame
        rx_vld  = 1'b1;
        rx_byte = 8'hEE;
        cycle();
        rx_vld = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("midreset_rx_len", {22'd0, rx_len}, 32'd0);
        chk("midreset_ram_wen", {31'd0, ram_wen}, 32'd0);
        chk("midreset_buf_full", {31'd0, buf_full}, 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        fb = '{8'h5A, 8'hC3};
        run_frame(0);
        do_ack(5);

        repeat (5) cycle();
        chk("writes_pending", exp_wr.size(), 32'd0);
        chk("deliveries_pending", exp_dl.size(), 32'd0);
        chk("widths_pending", exp_w.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
